arm_fetch_unit: RTL and testbench

//   Instruction fetch stage of arm_core: generates sequential word fetches on the

---
 rtl/arm_fetch_unit.sv | 109 ++++++++++
 tb/tb_arm_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch_unit.sv
// Fetch stage of arm_core: sequential word fetch over a one-cycle imem port,
// buffered into a prefetch FIFO and delivered to decode as {instr, pc}.
module arm_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  fetch_ent_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;

  logic          issue, push, pop;
  logic [CW:0]   credit_used;
  fetch_ent_t    head;

  // Credits count both buffered words and the one outstanding fetch, so the
  // response always has a free slot; a pop in the same cycle is not counted.
  always_comb begin
    credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    issue       = rst_n && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    push        = rst_n && imem_valid && inflight_q && !redirect_valid;
    out_valid   = rst_n && (count_q != '0);
    pop         = out_valid && out_ready;
    head        = fifo_q[rd_ptr_q];
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_pc    = out_valid ? head.pc    : 32'h0;

  always_comb begin
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;

    if (redirect_valid) begin
      // Flush everything; the outstanding fetch is orphaned by clearing inflight.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_pc & ~32'h3;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        fifo_d[wr_ptr_q].instr = imem_rdata;
        fifo_d[wr_ptr_q].pc    = inflight_pc_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: one-cycle memory model, redirect vector table,
// directed corner sequences and a randomized PC-stream scoreboard.
module tb_arm_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        mem_vld = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inj_vld = 1'b0;

  int errors = 0;
  int checks = 0;

  arm_fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Memory answers exactly one cycle after a sampled request; inj_vld forces
  // a spurious response carrying junk data.
  always @(posedge clk) begin
    mem_vld   <= imem_req;
    mem_rdata <= memf(imem_addr);
  end
  assign imem_valid = mem_vld | inj_vld;
  assign imem_rdata = inj_vld ? 32'hDEAD_BEEF : mem_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of the first cycle after reset release.
  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; inj_vld = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   32'(imem_req),  32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", out_instr,      32'h0);
    chk("rst_pc",    out_pc,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] rpc;
    logic        pre_ready;
    logic [31:0] e0;
    logic [31:0] e1;
  } rd_vec_t;

  rd_vec_t tbl [5];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nreq, got, last;
    logic [31:0] exp_pc, exp_req;
    int issued, delivered, starve;
    logic prev_redir;

    tbl[0] = '{32'h0000_0088, 1'b0, 32'h0000_0088, 32'h0000_008C};
    tbl[1] = '{32'h0000_0088, 1'b1, 32'h0000_0088, 32'h0000_008C};
    tbl[2] = '{32'h0000_0087, 1'b1, 32'h0000_0084, 32'h0000_0088};
    tbl[3] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[4] = '{32'h0000_1003, 1'b0, 32'h0000_1000, 32'h0000_1004};

    // Streaming from reset: one req per cycle, head appears two cycles later.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("t1_req",   32'(imem_req),  32'h1);
      chk("t1_addr",  imem_addr,      32'(k * 4));
      chk("t1_valid", 32'(out_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("t1_pc",    out_pc,    32'((k - 2) * 4));
        chk("t1_instr", out_instr, memf(32'((k - 2) * 4)));
      end
      @(negedge clk);
    end

    // Backpressure from reset: exactly FIFO_DEPTH reqs, head stable.
    do_reset();
    out_ready = 1'b0;
    nreq = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (imem_req) begin
        chk("t2_addr", imem_addr, 32'(nreq * 4));
        nreq++;
      end
      if (k >= 3) begin
        chk("t2_hold_pc",    out_pc,    32'h0);
        chk("t2_hold_instr", out_instr, memf(32'h0));
      end
      @(negedge clk);
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    out_ready = 1'b1;
    got = 0; last = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      #1;
      if (out_valid) begin
        chk("t2_pc",    out_pc,    32'(got * 4));
        chk("t2_instr", out_instr, memf(32'(got * 4)));
        if (got > 0) chk("t2_gap", 32'(c - last <= 3), 32'h1);
        last = c;
        got++;
      end
      @(negedge clk);
    end
    chk("t2_got", 32'(got), 32'd8);

    // Redirect vectors, with a spurious response injected in N+1.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      out_ready = tbl[i].pre_ready;
      repeat (4) begin #1; @(negedge clk); end
      redirect_valid = 1'b1; redirect_pc = tbl[i].rpc; out_ready = 1'b1;
      #1;
      chk("rd_n_req",   32'(imem_req),  32'h0);
      chk("rd_n_valid", 32'(out_valid), 32'h1);
      chk("rd_n_pc",    out_pc,         tbl[i].pre_ready ? 32'h8 : 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0; inj_vld = 1'b1;
      #1;
      chk("rd_n1_valid", 32'(out_valid), 32'h0);
      chk("rd_n1_req",   32'(imem_req),  32'h1);
      chk("rd_n1_addr",  imem_addr,      tbl[i].e0);
      @(negedge clk);
      inj_vld = 1'b0;
      #1;
      chk("rd_n2_valid", 32'(out_valid), 32'h0);
      chk("rd_n2_addr",  imem_addr,      tbl[i].e1);
      @(negedge clk);
      #1;
      chk("rd_n3_valid", 32'(out_valid), 32'h1);
      chk("rd_n3_pc",    out_pc,         tbl[i].e0);
      chk("rd_n3_instr", out_instr,      memf(tbl[i].e0));
      @(negedge clk);
      #1;
      chk("rd_n4_pc",    out_pc,         tbl[i].e1);
      chk("rd_n4_instr", out_instr,      memf(tbl[i].e1));
      @(negedge clk);
    end

    // Spurious responses while full and idle must not push.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      inj_vld = (k >= 6);
      #1;
      @(negedge clk);
    end
    inj_vld = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      #1;
      if (out_valid) begin
        chk("t5_pc",    out_pc,    32'(got * 4));
        chk("t5_instr", out_instr, memf(32'(got * 4)));
        got++;
      end
      @(negedge clk);
    end
    chk("t5_got", 32'(got), 32'd6);

    // Reset with a fetch outstanding: its response is dropped.
    do_reset();
    out_ready = 1'b1;
    #1; chk("t5r_req0", 32'(imem_req), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1; chk("t5r_rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; inj_vld = 1'b1;
    #1;
    chk("t5r_valid0", 32'(out_valid), 32'h0);
    chk("t5r_addr",   imem_addr,      32'h0);
    @(negedge clk);
    inj_vld = 1'b0;
    #1; chk("t5r_valid1", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("t5r_valid2", 32'(out_valid), 32'h1);
    chk("t5r_pc",     out_pc,         32'h0);
    chk("t5r_instr",  out_instr,      memf(32'h0));
    @(negedge clk);

    // Random ready and redirects against an address-stream model.
    do_reset();
    exp_pc = 32'h0; exp_req = 32'h0;
    issued = 0; delivered = 0; starve = 0; prev_redir = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      out_ready      = 1'($urandom_range(0, 1));
      #1;
      if (prev_redir) chk("r_post_redir_valid", 32'(out_valid), 32'h0);
      if (redirect_valid) chk("r_redir_req", 32'(imem_req), 32'h0);
      if (imem_req) begin
        chk("r_addr", imem_addr, exp_req);
        exp_req += 32'd4;
        issued++;
      end
      if (out_valid && out_ready) begin
        chk("r_pc",    out_pc,    exp_pc);
        chk("r_instr", out_instr, memf(exp_pc));
        exp_pc += 32'd4;
        delivered++;
      end
      chk("r_credit", 32'(issued - delivered <= 4), 32'h1);
      if (out_valid || redirect_valid) starve = 0;
      else starve++;
      chk("r_starve", 32'(starve <= 5), 32'h1);
      if (redirect_valid) begin
        exp_pc    = redirect_pc & ~32'h3;
        exp_req   = redirect_pc & ~32'h3;
        issued    = 0;
        delivered = 0;
      end
      prev_redir = redirect_valid;
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
